// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory and its load path.
// Provides the access-size encodings and the alignment rule used by both the
// memory and, later, the cache refill path.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Legal accesses: any byte, even-address halves, word-aligned words.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_sized_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Request: address, writeData, memwrite, memread, size, load_unsigned.
// Response: out32 (load data), rd_valid, misaligned.
interface data_mem_sized_if;

  logic [31:0] address;
  logic [31:0] writeData;
  logic        memwrite;
  logic        memread;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] out32;
  logic        rd_valid;
  logic        misaligned;

  modport master (
    output address, writeData, memwrite, memread, size, load_unsigned,
    input  out32, rd_valid, misaligned
  );

  modport slave (
    input  address, writeData, memwrite, memread, size, load_unsigned,
    output out32, rd_valid, misaligned
  );

endinterface

// File: rtl/load_extend.sv
// Extracts a byte/half/word from a big-endian 32-bit word and sign- or
// zero-extends it.
// Ports: raw (aligned word, lowest address in [31:24]), addr_lo (byte offset),
// size (mem_pkg encoding), load_unsigned (1 = zero-extend), result.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    half_v = 16'h0000;
    result = raw;

    // Big-endian lane select: offset 0 is the most significant byte.
    case (addr_lo)
      2'd0:    byte_v = raw[31:24];
      2'd1:    byte_v = raw[23:16];
      2'd2:    byte_v = raw[15:8];
      default: byte_v = raw[7:0];
    endcase
    half_v = addr_lo[1] ? raw[15:0] : raw[31:16];

    case (size)
      SZ_BYTE: result = load_unsigned ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: result = load_unsigned ? {16'h0000, half_v}   : {{16{half_v[15]}}, half_v};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed big-endian data memory for the MEM stage.
// Ports: clk, rst (async active-high), bus (slave side of data_mem_sized_if).
// Loads return one cycle after the request with rd_valid; illegal sizes or
// misaligned accesses raise a one-cycle misaligned pulse and have no effect.
module data_mem_sized
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter bit          INIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_sized_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned MEM_W = DEPTH * 8;
  localparam logic [63:0] IMG_LO  = 64'h00430822_8CA40006;
  localparam logic [31:0] IMG_TOP = 32'h11111111;

  // Power-up contents: test image in the first 8 bytes and the top word.
  function automatic logic [MEM_W-1:0] build_image();
    logic [MEM_W-1:0] img;
    img = '0;
    if (INIT_EN) begin
      for (int unsigned i = 0; i < 8; i++) begin
        img[i*8 +: 8] = IMG_LO[63 - 8*i -: 8];
      end
      img[(DEPTH-4)*8 +: 32] = IMG_TOP;
    end
    return img;
  endfunction

  // Byte i lives at mem[i*8 +: 8]; the array is never touched by reset.
  logic [MEM_W-1:0] mem = build_image();

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-3:0] wbase;
  logic              legal_c;
  logic              we_c;
  logic              re_c;
  logic              err_c;
  logic [31:0]       raw_c;
  logic [31:0]       ext_c;
  logic              unused_addr_hi;

  always_comb begin
    addr    = bus.address[ADDR_W-1:0];
    wbase   = addr[ADDR_W-1:2];
    legal_c = is_aligned(bus.size, addr[1:0]);
    we_c    = bus.memwrite & legal_c & ~rst;
    re_c    = bus.memread & legal_c;
    err_c   = (bus.memread | bus.memwrite) & ~legal_c;
    raw_c   = {mem[{wbase, 2'd0, 3'd0} +: 8], mem[{wbase, 2'd1, 3'd0} +: 8],
               mem[{wbase, 2'd2, 3'd0} +: 8], mem[{wbase, 2'd3, 3'd0} +: 8]};
  end

  assign unused_addr_hi = ^bus.address[31:ADDR_W];

  load_extend u_load_extend (
    .raw           (raw_c),
    .addr_lo       (addr[1:0]),
    .size          (bus.size),
    .load_unsigned (bus.load_unsigned),
    .result        (ext_c)
  );

  // Store path; reads above see pre-store contents on the same edge.
  always_ff @(posedge clk) begin
    if (we_c) begin
      case (bus.size)
        SZ_BYTE: mem[{addr, 3'd0} +: 8] <= bus.writeData[7:0];
        SZ_HALF: begin
          mem[{addr[ADDR_W-1:1], 1'b0, 3'd0} +: 8] <= bus.writeData[15:8];
          mem[{addr[ADDR_W-1:1], 1'b1, 3'd0} +: 8] <= bus.writeData[7:0];
        end
        SZ_WORD: begin
          mem[{wbase, 2'd0, 3'd0} +: 8] <= bus.writeData[31:24];
          mem[{wbase, 2'd1, 3'd0} +: 8] <= bus.writeData[23:16];
          mem[{wbase, 2'd2, 3'd0} +: 8] <= bus.writeData[15:8];
          mem[{wbase, 2'd3, 3'd0} +: 8] <= bus.writeData[7:0];
        end
        default: ;
      endcase
    end
  end

  // Registered response; out32 holds across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out32      <= 32'h0;
      bus.rd_valid   <= 1'b0;
      bus.misaligned <= 1'b0;
    end else begin
      bus.rd_valid   <= re_c;
      bus.misaligned <= err_c;
      if (re_c) begin
        bus.out32 <= ext_c;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_sized.sv
module tb_data_mem_sized;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mw;
    logic        mr;
    logic [1:0]  sz;
    logic        lu;
    logic [31:0] eout;
    logic        ev;
    logic        em;
  } vec_t;

  typedef struct {
    int          tag;
    logic [31:0] eout;
    logic        ev;
    logic        em;
  } exp_t;

  localparam int NV = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_mem_sized_if bus ();

  data_mem_sized #(.ADDR_W(8), .INIT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  vec_t vecs[NV];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wd,
                              input logic mw, input logic mr, input logic [1:0] sz,
                              input logic lu, input logic [31:0] eout,
                              input logic ev, input logic em);
    vec_t v;
    v.addr = addr; v.wd = wd; v.mw = mw; v.mr = mr; v.sz = sz; v.lu = lu;
    v.eout = eout; v.ev = ev; v.em = em;
    return v;
  endfunction

  task automatic check32(input string name, input int tag, input logic [31:0] act,
                         input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %08h expected %08h", name, tag, act, exp);
    end
  endtask

  task automatic check1(input string name, input int tag, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %b expected %b", name, tag, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.address       = v.addr;
    bus.writeData     = v.wd;
    bus.memwrite      = v.mw;
    bus.memread       = v.mr;
    bus.size          = v.sz;
    bus.load_unsigned = v.lu;
  endtask

  // Drive one request, queue its expectation, then compare after the edge.
  task automatic apply(input int tag, input vec_t v);
    exp_t e;
    exp_t got;
    drive(v);
    e.tag = tag; e.eout = v.eout; e.ev = v.ev; e.em = v.em;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard[%0d]: queue empty, expected an entry", tag);
    end else begin
      got = sb_q.pop_front();
      check32("out32", got.tag, bus.out32, got.eout);
      check1("rd_valid", got.tag, bus.rd_valid, got.ev);
      check1("misaligned", got.tag, bus.misaligned, got.em);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // addr, wd, mw, mr, size, lu, expected out32, rd_valid, misaligned
    vecs[0]  = mk(32'd0,   32'h0,        0, 1, 2'b10, 0, 32'h00430822, 1, 0);
    vecs[1]  = mk(32'd0,   32'h0,        0, 0, 2'b10, 0, 32'h00430822, 0, 0);
    vecs[2]  = mk(32'd4,   32'h0,        0, 1, 2'b00, 0, 32'hFFFFFF8C, 1, 0);
    vecs[3]  = mk(32'd4,   32'h0,        0, 1, 2'b00, 1, 32'h0000008C, 1, 0);
    vecs[4]  = mk(32'd4,   32'h0,        0, 1, 2'b01, 0, 32'hFFFF8CA4, 1, 0);
    vecs[5]  = mk(32'd6,   32'h0,        0, 1, 2'b01, 1, 32'h00000006, 1, 0);
    vecs[6]  = mk(32'd253, 32'h000000A5, 1, 0, 2'b00, 0, 32'h00000006, 0, 0);
    vecs[7]  = mk(32'd252, 32'h0,        0, 1, 2'b10, 0, 32'h11A51111, 1, 0);
    vecs[8]  = mk(32'd254, 32'h0000BEEF, 1, 0, 2'b01, 0, 32'h11A51111, 0, 0);
    vecs[9]  = mk(32'd252, 32'h0,        0, 1, 2'b10, 0, 32'h11A5BEEF, 1, 0);
    vecs[10] = mk(32'd2,   32'h12345678, 1, 0, 2'b10, 0, 32'h11A5BEEF, 0, 1);
    vecs[11] = mk(32'd0,   32'h0,        0, 1, 2'b10, 0, 32'h00430822, 1, 0);
    vecs[12] = mk(32'd5,   32'h0,        0, 1, 2'b01, 0, 32'h00430822, 0, 1);
    vecs[13] = mk(32'd0,   32'h0,        0, 1, 2'b11, 0, 32'h00430822, 0, 1);
    vecs[14] = mk(32'd5,   32'h0,        0, 1, 2'b00, 0, 32'hFFFFFFA4, 1, 0);
    vecs[15] = mk(32'd2,   32'h0,        0, 1, 2'b01, 0, 32'h00000822, 1, 0);
    vecs[16] = mk(32'd7,   32'h0,        0, 1, 2'b00, 0, 32'h00000006, 1, 0);
    vecs[17] = mk(32'hFFFFFF04, 32'h0,   0, 1, 2'b10, 0, 32'h8CA40006, 1, 0);
    vecs[18] = mk(32'd252, 32'h0,        0, 1, 2'b10, 1, 32'h11A5BEEF, 1, 0);
    vecs[19] = mk(32'd0,   32'hDEADBEEF, 1, 1, 2'b10, 0, 32'h00430822, 1, 0);
    vecs[20] = mk(32'd0,   32'h0,        0, 1, 2'b10, 0, 32'hDEADBEEF, 1, 0);
    vecs[21] = mk(32'd0,   32'h0,        0, 1, 2'b01, 0, 32'hFFFFDEAD, 1, 0);
    vecs[22] = mk(32'd0,   32'h0,        0, 1, 2'b01, 1, 32'h0000DEAD, 1, 0);
    vecs[23] = mk(32'd3,   32'h0,        0, 1, 2'b00, 1, 32'h000000EF, 1, 0);
    vecs[24] = mk(32'd0,   32'h0,        1, 0, 2'b11, 0, 32'h000000EF, 0, 1);
    vecs[25] = mk(32'd0,   32'h0,        0, 1, 2'b10, 0, 32'hDEADBEEF, 1, 0);
    vecs[26] = mk(32'h100, 32'h0,        0, 1, 2'b10, 0, 32'hDEADBEEF, 1, 0);
    vecs[27] = mk(32'd5,   32'h0000FFFF, 1, 0, 2'b01, 0, 32'hDEADBEEF, 0, 1);
    vecs[28] = mk(32'd4,   32'h0,        0, 1, 2'b10, 0, 32'h8CA40006, 1, 0);
    vecs[29] = mk(32'd0,   32'h0,        0, 0, 2'b00, 0, 32'h8CA40006, 0, 0);

    drive(mk(32'd0, 32'h0, 0, 0, 2'b00, 0, 32'h0, 0, 0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_out32", -1, bus.out32, 32'h0);
    check1("reset_rd_valid", -1, bus.rd_valid, 1'b0);
    check1("reset_misaligned", -1, bus.misaligned, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(i, vecs[i]);
    end

    // Async reset between edges discards a pending load result.
    apply(100, mk(32'd252, 32'h0, 0, 1, 2'b10, 0, 32'h11A5BEEF, 1, 0));
    #1;
    drive(mk(32'd4, 32'hFFFFFFFF, 1, 0, 2'b10, 0, 32'h0, 0, 0));
    rst = 1'b1;
    #1;
    check32("async_rst_out32", 101, bus.out32, 32'h0);
    check1("async_rst_rd_valid", 101, bus.rd_valid, 1'b0);
    check1("async_rst_misaligned", 101, bus.misaligned, 1'b0);

    // Store held across reset edges must be dropped.
    repeat (2) @(posedge clk);
    #1;
    check32("held_rst_out32", 102, bus.out32, 32'h0);
    check1("held_rst_rd_valid", 102, bus.rd_valid, 1'b0);
    drive(mk(32'd0, 32'h0, 0, 0, 2'b00, 0, 32'h0, 0, 0));
    rst = 1'b0;
    apply(103, mk(32'd0, 32'h0, 0, 0, 2'b00, 0, 32'h00000000, 0, 0));
    apply(104, mk(32'd4, 32'h0, 0, 1, 2'b10, 0, 32'h8CA40006, 1, 0));
    apply(105, mk(32'd0, 32'h0, 0, 1, 2'b10, 0, 32'hDEADBEEF, 1, 0));
    apply(106, mk(32'd0, 32'h0, 0, 0, 2'b00, 0, 32'hDEADBEEF, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
